// File: rtl/receive_bdeduffy_pkg.sv
// Shared types and constants for the parity-protected counter channel receiver.
package rx_pkg_bdeduffy;

  localparam int PAYLOAD_W = 9;
  localparam int WORD_W    = 10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // Payload field of a received {parity, payload} word.
  function automatic logic [PAYLOAD_W-1:0] payload_of(input logic [WORD_W-1:0] word);
    return word[PAYLOAD_W-1:0];
  endfunction

endpackage

// File: rtl/receive_bdeduffy_parity10.sv
// Even-parity checker over the full 10-bit word; mirrors the transmit-side generator.
module parity10_bdeduffy
  import rx_pkg_bdeduffy::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              good
);

  assign good = ~(^word);

endmodule

// File: rtl/receive_bdeduffy.sv
// Receive stage: parity and sequence checking, lock acquisition/tracking, payload forwarding.
// Optional feature macro: RX_SEQ_CHECK_EN (defined = sequence checking; undefined = parity only).
module receive_bdeduffy
  import rx_pkg_bdeduffy::*;
#(
  parameter int unsigned ERR_CNT_W        = 8,
  parameter int unsigned LOCK_LOSS_THRESH = 4,
  parameter int unsigned RESYNC_GOOD      = 2
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [WORD_W-1:0]    data_in,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int GR_W = $clog2(RESYNC_GOOD + 1);
  localparam int BR_W = $clog2(LOCK_LOSS_THRESH + 1);

  rx_state_e             state_q, state_d;
  logic [GR_W-1:0]       good_run_q, good_run_d;
  logic [BR_W-1:0]       bad_run_q, bad_run_d;
  logic [PAYLOAD_W-1:0]  data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  seq_err_q, seq_err_d;
  logic                  locked_q;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic                  good_s;
  logic                  in_seq_s;
  logic [PAYLOAD_W-1:0]  payload_s;
  logic [GR_W-1:0]       good_run_inc_s;
  logic [BR_W-1:0]       bad_run_inc_s;
  logic [ERR_CNT_W-1:0]  err_count_inc_s;

  parity10_bdeduffy u_parity (
    .word (data_in),
    .good (good_s)
  );

  assign payload_s       = payload_of(data_in);
  assign good_run_inc_s  = good_run_q + GR_W'(1);
  assign bad_run_inc_s   = bad_run_q + BR_W'(1);
  assign err_count_inc_s = (err_count_q == {ERR_CNT_W{1'b1}}) ? err_count_q
                                                              : err_count_q + ERR_CNT_W'(1);

`ifdef RX_SEQ_CHECK_EN
  logic [PAYLOAD_W-1:0] expected_q, expected_d;
  assign in_seq_s = (payload_s == expected_q);
`else
  // Without sequence checking every parity-good word is treated as in-sequence.
  assign in_seq_s = 1'b1;
`endif

  // Next-state, tracking counters and output pulses for one enabled sample.
  always_comb begin
    state_d      = state_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    seq_err_d    = 1'b0;
    err_count_d  = err_count_q;
`ifdef RX_SEQ_CHECK_EN
    expected_d   = expected_q;
`endif
    if (enable) begin
      case (state_q)
        HUNT: begin
          if (good_s) begin
            good_run_d = GR_W'(1);
            bad_run_d  = BR_W'(0);
`ifdef RX_SEQ_CHECK_EN
            expected_d = payload_s + PAYLOAD_W'(1);
`endif
            if (RESYNC_GOOD == 1) begin
              state_d = LOCKED;
            end else begin
              state_d = SYNC;
            end
          end else begin
            state_d = HUNT;
          end
        end
        SYNC: begin
          if (good_s && in_seq_s) begin
            good_run_d = good_run_inc_s;
`ifdef RX_SEQ_CHECK_EN
            expected_d = expected_q + PAYLOAD_W'(1);
`endif
            if (good_run_inc_s == GR_W'(RESYNC_GOOD)) begin
              state_d = LOCKED;
            end else begin
              state_d = SYNC;
            end
          end else begin
            good_run_d = GR_W'(0);
            state_d    = HUNT;
          end
        end
        LOCKED: begin
          if (!good_s) begin
            // Parity failure takes precedence; expected free-runs past the lost word.
            parity_err_d = 1'b1;
            bad_run_d    = bad_run_inc_s;
            err_count_d  = err_count_inc_s;
`ifdef RX_SEQ_CHECK_EN
            expected_d   = expected_q + PAYLOAD_W'(1);
`endif
          end else if (in_seq_s) begin
            data_valid_d = 1'b1;
            data_out_d   = payload_s;
            bad_run_d    = BR_W'(0);
`ifdef RX_SEQ_CHECK_EN
            expected_d   = expected_q + PAYLOAD_W'(1);
`endif
          end else begin
            // Out-of-sequence but intact: forward it and re-align on it.
            seq_err_d    = 1'b1;
            data_valid_d = 1'b1;
            data_out_d   = payload_s;
            bad_run_d    = bad_run_inc_s;
            err_count_d  = err_count_inc_s;
`ifdef RX_SEQ_CHECK_EN
            expected_d   = payload_s + PAYLOAD_W'(1);
`endif
          end
          if ((parity_err_d || seq_err_d) && (bad_run_inc_s == BR_W'(LOCK_LOSS_THRESH))) begin
            state_d    = HUNT;
            bad_run_d  = BR_W'(0);
            good_run_d = GR_W'(0);
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= HUNT;
      good_run_q   <= GR_W'(0);
      bad_run_q    <= BR_W'(0);
      data_out_q   <= PAYLOAD_W'(0);
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      locked_q     <= 1'b0;
      err_count_q  <= ERR_CNT_W'(0);
`ifdef RX_SEQ_CHECK_EN
      expected_q   <= PAYLOAD_W'(0);
`endif
    end else begin
      state_q      <= state_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      seq_err_q    <= seq_err_d;
      locked_q     <= (state_d == LOCKED);
      err_count_q  <= err_count_d;
`ifdef RX_SEQ_CHECK_EN
      expected_q   <= expected_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
`ifdef RX_SEQ_CHECK_EN
  assign seq_err    = seq_err_q;
`else
  assign seq_err    = 1'b0;
`endif
  assign locked     = locked_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/receive_bdeduffy.md
# receive_bdeduffy

Receive stage of the parity-protected counter channel. Consumes the 10-bit word `{parity, count[8:0]}` produced by the transmit stage, where bit 9 makes the 10-bit XOR equal zero. It checks parity and sequence continuity, acquires and tracks lock, and forwards good payloads with error reporting.

## Interface
- `ERR_CNT_W`, 8, width of the saturating error counter
- `LOCK_LOSS_THRESH`, 4, consecutive bad words in LOCKED that drop lock (≥1)
- `RESYNC_GOOD`, 2, consecutive good in-sequence words in SYNC needed to lock (≥1)

- `clk`  in  1  sole clock, rising edge
- `clear`  in  1  reset, synchronous, active-high
- `enable`  in  1  sample qualifier; integrator aligns it to the transmit register output (transmit enable delayed one cycle)
- `data_in`  in  10  `{parity, payload[8:0]}`
- `data_out`  out  9  last accepted payload
- `data_valid`  out  1  one-cycle pulse, `data_out` updated
- `parity_err`  out  1  one-cycle pulse, sampled word failed parity
- `seq_err`  out  1  one-cycle pulse, parity-good payload ≠ expected
- `locked`  out  1  high in LOCKED
- `err_count`  out  `ERR_CNT_W`  saturating count of errors while LOCKED

## Operation
- **Word good:** XOR of `data_in[9:0]` is 0. **In-sequence:** payload equals `expected`. `expected` is 9-bit and wraps 511→0.
- `enable=0`: no state change and no pulses. All of the following applies only on enabled cycles.
- **HUNT** (reset state):
  - Good word: `expected` ← payload+1, `good_run` ← 1, go to SYNC. If `RESYNC_GOOD`=1, go straight to LOCKED.
  - Bad word: stay in HUNT.
  - No pulses are issued in HUNT.
- **SYNC:**
  - Good and in-sequence: `good_run`++ and `expected`++. When `good_run` reaches `RESYNC_GOOD`, go to LOCKED.
  - Any parity or sequence failure: go to HUNT. No pulses.
- **LOCKED:**
  - Good and in-sequence: `data_valid`, `data_out` ← payload, `bad_run` ← 0, `expected`++.
  - Parity bad: `parity_err`, `bad_run`++, `expected`++ (free-run). `seq_err` is suppressed; parity takes precedence.
  - Good but out-of-sequence: `seq_err`, `bad_run`++, `expected` ← payload+1 (re-align). `data_valid` is still issued with the payload.
  - Each error increments `err_count`, which saturates at all-ones.
  - When `bad_run` reaches `LOCK_LOSS_THRESH`, go to HUNT. The pulse for that error is still issued.
- `err_count` is cleared only by `clear`. It holds across lock loss.

## Timing
- All outputs are registered. Pulses and `data_out` appear in the cycle after the sampling edge, so latency is 1 clock.
- `locked` changes in the same cycle as the state register.
- **Reset values:** state HUNT, `data_out` 0, all pulses 0, `locked` 0, `err_count` 0, `expected` 0, `good_run` 0, `bad_run` 0.
- `clear` overrides `enable` and any in-flight error. Mid-stream clear forces HUNT on the next edge.
- Back-to-back enabled words are supported every cycle. No backpressure.

## Configuration
- `RX_SEQ_CHECK_EN`
  - **Defined:** sequence checking as above.
  - **Undefined:** every parity-good word counts as in-sequence. `seq_err` is tied to 0. The `expected` register is removed. Locking depends on parity alone.

## Structure
- Package `rx_pkg_bdeduffy` holds:
  - state enum `{HUNT, SYNC, LOCKED}`
  - `PAYLOAD_W=9`, `WORD_W=10`
- Sub-module `parity10_bdeduffy`: combinational 10-bit XOR producing `good`. It mirrors the transmit-side parity generator.

## Test plan
- Reset, then continuous count 0,1,2… with correct parity (`RESYNC_GOOD`=2):
  - `locked` rises after the 2nd word.
  - `data_valid` pulses from the 3rd word on, with `data_out` = 2, 3, …
  - No errors.
- Locked stream 509→510→511→0→1: no `seq_err`, and `data_out` wraps to 0.
- Locked; flip bit 4 on the word carrying 20:
  - One `parity_err` and no `seq_err`.
  - `err_count` = 1.
  - The word for 21 is accepted.
- Locked; skip from 30 to 35:
  - One `seq_err` with `data_out` = 35.
  - 36 is accepted cleanly.
  - `err_count` increments once.
  - With the macro undefined, none of this flags.
- Locked; 4 consecutive parity-bad words:
  - 4 `parity_err` pulses.
  - `locked` falls after the 4th.
  - A good stream re-locks after 2 words, and `err_count` keeps 4.
- Drive `err_count` to 255 (`ERR_CNT_W`=8) and inject a further error: `err_count` stays 255. Assert `clear` mid-stream: all outputs return to reset values on the next cycle.
